// File: rtl/pipe_front_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_front_ctrl
// Purpose  : Front-end pipeline state holder. Owns the fetch PC, the IF/ID
//            register and the ID/EX control register. Consumes load-use stall
//            (PCWrite) and bubble (detection_flush) requests from the hazard
//            detector and branch redirects from EX. Feeds IF_ID_rs1/rs2 and
//            ID_EX_rd/ID_EX_MemRead back to the hazard detector.
// Macro    : PIPE_PERF_CNT_EN - when defined, adds stall/flush counters;
//            when undefined, stall_cycles and flush_count are tied to 0.
// Ports    :
//   clk, rstn               clock, synchronous active-low reset
//   PCWrite                 0 = load-use stall (hold PC and IF/ID)
//   detection_flush         1 = insert bubble into ID/EX during a stall
//   branch_taken/_target    EX redirect request and target PC
//   fetch_valid/fetch_inst  imem response for the current PC
//   id_MemRead/Write/RegWrite decoded controls of the instruction in ID
//   pc                      current fetch PC
//   IF_ID_*                 ID stage contents and rs1/rs2 fields
//   ID_EX_*                 EX stage pc, rd and controls
//   stall_cycles/flush_count performance counters
// Revision : 1.0 - initial release
// ============================================================================
module pipe_front_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        PCWrite,
  input  logic        detection_flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_inst,
  input  logic        id_MemRead,
  input  logic        id_MemWrite,
  input  logic        id_RegWrite,
  output logic [31:0] pc,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_inst,
  output logic        IF_ID_valid,
  output logic [4:0]  IF_ID_rs1,
  output logic [4:0]  IF_ID_rs2,
  output logic [31:0] ID_EX_pc,
  output logic [4:0]  ID_EX_rd,
  output logic        ID_EX_MemRead,
  output logic        ID_EX_MemWrite,
  output logic        ID_EX_RegWrite,
  output logic        ID_EX_valid,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] ex_pc_q, ex_pc_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        ex_mr_q, ex_mr_d;
  logic        ex_mw_q, ex_mw_d;
  logic        ex_rw_q, ex_rw_d;
  logic        ex_valid_q, ex_valid_d;

  // ID/EX contents as decoded from the current IF/ID slot. Every field,
  // including rd, is gated by IF_ID_valid so a bubble can never raise a
  // false hazard downstream.
  logic [31:0] dec_pc;
  logic [4:0]  dec_rd;
  logic        dec_mr, dec_mw, dec_rw;

  always_comb begin
    dec_pc = if_valid_q ? if_pc_q : 32'h0;
    dec_rd = if_valid_q ? if_inst_q[11:7] : 5'd0;
    dec_mr = if_valid_q & id_MemRead;
    dec_mw = if_valid_q & id_MemWrite;
    dec_rw = if_valid_q & id_RegWrite;
  end

  always_comb begin
    // Default: normal advance.
    pc_d       = pc_q + 32'd4;
    if_pc_d    = pc_q;
    if_inst_d  = fetch_inst;
    if_valid_d = 1'b1;
    ex_pc_d    = dec_pc;
    ex_rd_d    = dec_rd;
    ex_mr_d    = dec_mr;
    ex_mw_d    = dec_mw;
    ex_rw_d    = dec_rw;
    ex_valid_d = if_valid_q;

    if (branch_taken) begin
      // Redirect squashes both younger stages; stall requests are moot.
      pc_d       = branch_target;
      if_pc_d    = 32'h0;
      if_inst_d  = NOP_INST;
      if_valid_d = 1'b0;
      ex_pc_d    = 32'h0;
      ex_rd_d    = 5'd0;
      ex_mr_d    = 1'b0;
      ex_mw_d    = 1'b0;
      ex_rw_d    = 1'b0;
      ex_valid_d = 1'b0;
    end else if (!PCWrite) begin
      // Load-use stall: hold fetch and ID; the fetched word is dropped and
      // the same PC is fetched again next cycle.
      pc_d       = pc_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      if_valid_d = if_valid_q;
      if (detection_flush) begin
        ex_pc_d    = 32'h0;
        ex_rd_d    = 5'd0;
        ex_mr_d    = 1'b0;
        ex_mw_d    = 1'b0;
        ex_rw_d    = 1'b0;
        ex_valid_d = 1'b0;
      end
    end else if (!fetch_valid) begin
      // Fetch miss: PC waits for imem, ID drains into EX.
      pc_d       = pc_q;
      if_pc_d    = 32'h0;
      if_inst_d  = NOP_INST;
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q       <= RESET_PC;
      if_pc_q    <= 32'h0;
      if_inst_q  <= NOP_INST;
      if_valid_q <= 1'b0;
      ex_pc_q    <= 32'h0;
      ex_rd_q    <= 5'd0;
      ex_mr_q    <= 1'b0;
      ex_mw_q    <= 1'b0;
      ex_rw_q    <= 1'b0;
      ex_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_rd_q    <= ex_rd_d;
      ex_mr_q    <= ex_mr_d;
      ex_mw_q    <= ex_mw_d;
      ex_rw_q    <= ex_rw_d;
      ex_valid_q <= ex_valid_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (branch_taken) begin
      flush_d = flush_q + 32'd1;
    end else if (!PCWrite) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_q <= 32'h0;
      flush_q <= 32'h0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = 32'h0;
  assign flush_count  = 32'h0;
`endif

  assign pc             = pc_q;
  assign IF_ID_pc       = if_pc_q;
  assign IF_ID_inst     = if_inst_q;
  assign IF_ID_valid    = if_valid_q;
  assign IF_ID_rs1      = if_inst_q[19:15];
  assign IF_ID_rs2      = if_inst_q[24:20];
  assign ID_EX_pc       = ex_pc_q;
  assign ID_EX_rd       = ex_rd_q;
  assign ID_EX_MemRead  = ex_mr_q;
  assign ID_EX_MemWrite = ex_mw_q;
  assign ID_EX_RegWrite = ex_rw_q;
  assign ID_EX_valid    = ex_valid_q;

endmodule
`default_nettype wire

// File: doc/pipe_front_ctrl.md
Name: pipe_front_ctrl

Overview:
- Front-end pipeline state holder and consumer of the load-use stall and flush requests: PC register, IF/ID register and ID/EX control register.
- Applies PCWrite / detection_flush from the hazard detector and branch redirects from EX.
- Returns IF_ID_rs1, IF_ID_rs2, ID_EX_rd and ID_EX_MemRead to the hazard detector, closing the stall loop.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction word used as a bubble (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  synchronous active-low reset, sampled on rising clk.
- PCWrite  input  1  0 = load-use stall (hold PC and IF/ID).
- detection_flush  input  1  1 = insert bubble into ID/EX.
- branch_taken  input  1  EX redirect request.
- branch_target  input  32  redirect PC.
- fetch_valid  input  1  imem returned a valid word for current PC this cycle.
- fetch_inst  input  32  instruction word for current PC.
- id_MemRead, id_MemWrite, id_RegWrite  input  1 each  decoded ID controls.
- pc  output  32  current fetch PC.
- IF_ID_pc  output  32  PC of instruction in ID.
- IF_ID_inst  output  32  instruction in ID.
- IF_ID_valid  output  1  ID slot holds a real instruction.
- IF_ID_rs1, IF_ID_rs2  output  5  IF_ID_inst[19:15], [24:20] (combinational from register).
- ID_EX_pc  output  32  PC of instruction in EX.
- ID_EX_rd  output  5  destination in EX.
- ID_EX_MemRead, ID_EX_MemWrite, ID_EX_RegWrite, ID_EX_valid  output  1 each  EX controls.
- stall_cycles, flush_count  output  32 each  performance counters (see Optional Feature).

Behaviour:
- Reset (rstn=0 at edge): pc=RESET_PC; IF_ID_pc=0, IF_ID_inst=NOP_INST, IF_ID_valid=0; all ID_EX_* = 0; counters = 0. Reset wins over every other input, including mid-stall and mid-redirect.
- Per-edge priority: reset > branch_taken > stall (PCWrite=0) > fetch miss (fetch_valid=0) > normal advance.
- Redirect (branch_taken=1):
  - pc <= branch_target.
  - IF/ID <= bubble (NOP_INST, valid 0, pc 0).
  - ID/EX <= bubble (all controls 0, rd 0, valid 0).
  - Stall and detection_flush are ignored that cycle.
- Stall (PCWrite=0, no redirect):
  - pc and IF/ID hold.
  - ID/EX <= bubble if detection_flush=1; otherwise ID/EX <= decoded ID fields.
  - fetch_inst is discarded; the same PC is re-fetched next cycle.
- Fetch miss (fetch_valid=0, PCWrite=1, no redirect):
  - pc holds.
  - IF/ID <= bubble.
  - ID/EX <= decoded fields of the current IF/ID (the pipeline drains).
- Normal advance:
  - pc <= pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - IF/ID <= {pc, fetch_inst, 1}.
  - ID/EX <= {IF_ID_pc, IF_ID_inst[11:7], id_MemRead, id_MemWrite, id_RegWrite, IF_ID_valid}, with the controls gated by IF_ID_valid.
- A bubble is never allowed to carry a nonzero ID_EX_rd or asserted controls. Hazard feedback from a bubble is therefore always inert.
- Latency: instruction fetched in cycle N is in ID at N+1 and in EX at N+2 when there are no stalls. Each stall cycle adds exactly 1.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cycles increments by 1 on every non-reset edge with PCWrite=0 and branch_taken=0.
  - flush_count increments on every non-reset edge with branch_taken=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both outputs are constant 0 and no counter registers exist.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with RESET_PC=32'h100 -> pc=0x100, IF_ID_inst=0x00000013, IF_ID_valid=0, ID_EX_MemRead=0 throughout. First edge after release -> pc=0x104.
- Straight-line: fetch_valid=1 with insts A,B,C at 0x0, 0x4, 0x8 -> A in ID at cycle 1 and in EX at cycle 2 (ID_EX_pc=0x0); pc=0xC after 3 edges.
- Load-use: PCWrite=0 and detection_flush=1 for one edge while IF_ID_pc=0x8 -> pc holds, IF_ID_pc stays 0x8, ID_EX_valid=0, ID_EX_rd=0. Next edge advances normally. stall_cycles=1 with the macro defined, 0 without.
- Redirect over stall: branch_taken=1, branch_target=0x40, PCWrite=0 on the same edge -> pc=0x40, IF_ID_valid=0, ID_EX_valid=0; flush_count=1 with the macro defined.
- Fetch miss: fetch_valid=0 for 2 cycles at pc=0x20 -> pc stays 0x20, two bubbles enter IF/ID then ID/EX. Restoring fetch_valid=1 -> instruction at 0x20 reaches ID next edge.
- Wrap and reset mid-stall:
  - pc=0xFFFFFFFC, normal advance -> pc=0.
  - Assert rstn=0 while PCWrite=0 -> pc=RESET_PC and all ID/EX fields 0 on that edge.
